// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Purpose:
//   This is the instruction fetch stage that sits right after the PC register.
//   On fetchStart it captures pcCur and issues a request/acknowledge read to
//   instruction memory. It keeps the returned word in an instruction register
//   until the decoder takes it. Each completed fetch produces a one-cycle
//   pcAdvance pulse. A flush drops any fetch that is in flight and any word
//   that is held. A memory that never acknowledges sets a sticky fault.
//
// Optional feature:
//   FETCH_ALIGN_CHECK_EN - when this macro is defined, a fetch request at an
//   odd pcCur is refused and the sticky misaligned flag is set. When it is
//   not defined, misaligned stays 0 and odd addresses are fetched as usual.
//
// Parameters:
//   MAX_WAIT   number of unacknowledged REQ cycles allowed before a timeout
//              (1..255)
//
// Ports:
//   clock      system clock; every state update happens on its rising edge
//   reset      synchronous, active-high reset
//   pcCur      current PC from the PC register
//   fetchStart control asks for a fetch of pcCur
//   flush      discard any in-flight or held instruction
//   memReq     read request to instruction memory
//   memAddr    read address, stable while memReq is high
//   memAck     memory data is valid this cycle
//   memData    instruction word from memory
//   instOut    held instruction word
//   fetchPc    address that instOut was fetched from
//   instValid  instOut/fetchPc are valid for decode
//   instTaken  decode consumes instOut this cycle
//   pcAdvance  one-cycle pulse for each completed fetch
//   busy       high while a request is outstanding
//   fault      sticky memory-timeout flag
//   misaligned sticky odd-address flag
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pcCur,
    input  logic        fetchStart,
    input  logic        flush,
    output logic        memReq,
    output logic [15:0] memAddr,
    input  logic        memAck,
    input  logic [15:0] memData,
    output logic [15:0] instOut,
    output logic [15:0] fetchPc,
    output logic        instValid,
    input  logic        instTaken,
    output logic        pcAdvance,
    output logic        busy,
    output logic        fault,
    output logic        misaligned
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [1:0] stateR;
    logic [7:0] waitCntR;
    logic       oddPcS;

`ifdef FETCH_ALIGN_CHECK_EN
    // A fetch request at an odd PC is refused.
    assign oddPcS = pcCur[0];
`else
    // Without the alignment check, every address is fetched as it is.
    assign oddPcS = 1'b0;
`endif

    // Fetch FSM together with all of its registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            stateR     <= IDLE;
            waitCntR   <= 8'd0;
            memReq     <= 1'b0;
            busy       <= 1'b0;
            memAddr    <= 16'h0000;
            instOut    <= 16'h0000;
            fetchPc    <= 16'h0000;
            instValid  <= 1'b0;
            pcAdvance  <= 1'b0;
            fault      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            // pcAdvance is a pulse. It is cleared every cycle unless the
            // branch for a completed fetch sets it again.
            pcAdvance <= 1'b0;
            if (flush) begin
                // A flush overrides everything else in its cycle, including
                // a memAck that arrives at the same time.
                stateR    <= IDLE;
                memReq    <= 1'b0;
                busy      <= 1'b0;
                instValid <= 1'b0;
            end else begin
                case (stateR)
                    IDLE: begin
                        if (fetchStart) begin
                            if (oddPcS) begin
                                misaligned <= 1'b1;
                            end else begin
                                memAddr  <= pcCur;
                                waitCntR <= 8'd0;
                                memReq   <= 1'b1;
                                busy     <= 1'b1;
                                stateR   <= REQ;
                            end
                        end
                    end
                    REQ: begin
                        if (memAck) begin
                            instOut   <= memData;
                            fetchPc   <= memAddr;
                            instValid <= 1'b1;
                            pcAdvance <= 1'b1;
                            memReq    <= 1'b0;
                            busy      <= 1'b0;
                            stateR    <= HOLD;
                        end else if (waitCntR == MAX_WAIT_C) begin
                            // The counter started at 0 in the first REQ
                            // cycle, so MAX_WAIT+1 cycles have gone by
                            // without an acknowledge.
                            fault  <= 1'b1;
                            memReq <= 1'b0;
                            busy   <= 1'b0;
                            stateR <= IDLE;
                        end else begin
                            waitCntR <= waitCntR + 8'd1;
                        end
                    end
                    HOLD: begin
                        // While the word is held, fetchStart has effect only
                        // when decode takes the word in the same cycle.
                        if (instTaken) begin
                            instValid <= 1'b0;
                            if (fetchStart && !oddPcS) begin
                                memAddr  <= pcCur;
                                waitCntR <= 8'd0;
                                memReq   <= 1'b1;
                                busy     <= 1'b1;
                                stateR   <= REQ;
                            end else begin
                                if (fetchStart) begin
                                    misaligned <= 1'b1;
                                end
                                stateR <= IDLE;
                            end
                        end
                    end
                    default: begin
                        stateR    <= IDLE;
                        memReq    <= 1'b0;
                        busy      <= 1'b0;
                        instValid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// This is the self-checking bench for inst_fetch. Each fetch is described at
// the transaction level: a PC, an acknowledge delay, a data word and a flush
// choice. The bench works out the expected request length, the result
// registers, the pcAdvance pulses and the sticky flags from those values.
// FETCH_ALIGN_CHECK_EN selects the expected behaviour for odd addresses.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int MAX_WAIT = 15;

    logic        clock;
    logic        reset;
    logic [15:0] pcCur;
    logic        fetchStart;
    logic        flush;
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck;
    logic [15:0] memData;
    logic [15:0] instOut;
    logic [15:0] fetchPc;
    logic        instValid;
    logic        instTaken;
    logic        pcAdvance;
    logic        busy;
    logic        fault;
    logic        misaligned;

    int testsRun    = 0;
    int testsFailed = 0;
    int advSeen     = 0;
    int expAdv      = 0;
    bit expFault    = 1'b0;

    inst_fetch #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock      (clock),
        .reset      (reset),
        .pcCur      (pcCur),
        .fetchStart (fetchStart),
        .flush      (flush),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memData    (memData),
        .instOut    (instOut),
        .fetchPc    (fetchPc),
        .instValid  (instValid),
        .instTaken  (instTaken),
        .pcAdvance  (pcAdvance),
        .busy       (busy),
        .fault      (fault),
        .misaligned (misaligned)
    );

    // Free-running clock with a 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every pcAdvance pulse across the whole run.
    always @(negedge clock) begin
        if (pcAdvance === 1'b1) advSeen++;
    end

    // Stop a runaway simulation.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Go to the next rising edge, then move 3 ns past it for sampling and
    // driving.
    task automatic tick();
        @(posedge clock);
        #3;
    endtask

    // Run one fetch. delay is the index of the REQ cycle that receives the
    // acknowledge. A delay above MAX_WAIT means no acknowledge comes.
    task automatic doFetch(input logic [15:0] pc, input int delay, input logic [15:0] data,
                           input bit doFlush, input bit fromHold);
        int reqSeen;
        bit timeout;
        bit done;
        reqSeen = 0;
        done    = 1'b0;
        timeout = (delay > MAX_WAIT);
        pcCur      = pc;
        fetchStart = 1'b1;
        instTaken  = fromHold;
        tick();
        fetchStart = 1'b0;
        instTaken  = 1'b0;
        pcCur      = 16'($urandom);
        checkVal("req_latency", 32'(memReq), 32'd1);
        checkVal("busy_in_req", 32'(busy), 32'd1);
        checkVal("valid_in_req", 32'(instValid), 32'd0);
        for (int k = 0; k <= MAX_WAIT + 2 && !done; k++) begin
            if (memReq) reqSeen++;
            checkVal("addr_stable", 32'(memAddr), 32'(pc));
            if (!timeout && k == delay) begin
                memAck  = 1'b1;
                memData = data;
                flush   = doFlush;
            end else begin
                memAck  = 1'b0;
                memData = 16'($urandom);
            end
            tick();
            memAck = 1'b0;
            flush  = 1'b0;
            if ((!timeout && k == delay) || !memReq) done = 1'b1;
        end
        checkVal("req_bounded", 32'(done), 32'd1);
        checkVal("req_cycles", 32'(reqSeen), timeout ? 32'(MAX_WAIT + 1) : 32'(delay + 1));
        checkVal("req_drop", 32'(memReq), 32'd0);
        if (timeout) begin
            expFault = 1'b1;
            checkVal("timeout_fault", 32'(fault), 32'd1);
            checkVal("timeout_no_adv", 32'(pcAdvance), 32'd0);
            checkVal("timeout_no_valid", 32'(instValid), 32'd0);
        end else if (doFlush) begin
            checkVal("flush_no_valid", 32'(instValid), 32'd0);
            checkVal("flush_no_adv", 32'(pcAdvance), 32'd0);
        end else begin
            expAdv++;
            checkVal("ack_valid", 32'(instValid), 32'd1);
            checkVal("ack_adv", 32'(pcAdvance), 32'd1);
            checkVal("ack_inst", 32'(instOut), 32'(data));
            checkVal("ack_fetchpc", 32'(fetchPc), 32'(pc));
        end
        tick();
        checkVal("adv_one_cycle", 32'(pcAdvance), 32'd0);
        checkVal("fault_sticky", 32'(fault), 32'(expFault));
    endtask

    // Cycles in HOLD with stray fetchStart/memAck and no instTaken. The held
    // word must not change.
    task automatic holdStrays(input logic [15:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            fetchStart = 1'($urandom);
            memAck     = 1'($urandom);
            memData    = 16'($urandom);
            tick();
            fetchStart = 1'b0;
            memAck     = 1'b0;
            checkVal("hold_valid", 32'(instValid), 32'd1);
            checkVal("hold_inst", 32'(instOut), 32'(data));
            checkVal("hold_no_req", 32'(memReq), 32'd0);
        end
    endtask

    // Leave HOLD through instTaken or flush. After that, a stray memAck in
    // IDLE must be ignored.
    task automatic holdEnd(input logic [15:0] data, input bit useFlush);
        holdStrays(data, $urandom_range(0, 2));
        if (useFlush) flush = 1'b1;
        else instTaken = 1'b1;
        tick();
        flush     = 1'b0;
        instTaken = 1'b0;
        checkVal("release_valid", 32'(instValid), 32'd0);
        checkVal("release_no_req", 32'(memReq), 32'd0);
        memAck  = 1'b1;
        memData = 16'($urandom);
        tick();
        memAck = 1'b0;
        checkVal("idle_ack_ignored", 32'(instValid | pcAdvance | memReq), 32'd0);
    endtask

    initial begin
        logic [15:0] pc;
        logic [15:0] data;
        logic [15:0] lastData;
        int          delay;
        bit          fl;
        bit          inHold;

        reset      = 1'b1;
        pcCur      = 16'h0000;
        fetchStart = 1'b0;
        flush      = 1'b0;
        memAck     = 1'b0;
        memData    = 16'h0000;
        instTaken  = 1'b0;
        tick();
        tick();
        checkVal("rst_ctrl", 32'({memReq, instValid, pcAdvance, busy, fault, misaligned}), 32'd0);
        checkVal("rst_inst", 32'(instOut), 32'd0);
        checkVal("rst_fetchpc", 32'(fetchPc), 32'd0);
        checkVal("rst_addr", 32'(memAddr), 32'd0);
        reset = 1'b0;
        tick();

        // Zero-wait fetch.
        doFetch(16'h0010, 0, 16'hA5C3, 1'b0, 1'b0);
        holdEnd(16'hA5C3, 1'b0);
        // Acknowledge in the fourth REQ cycle.
        doFetch(16'h0020, 3, 16'h1234, 1'b0, 1'b0);
        holdEnd(16'h1234, 1'b1);
        // No acknowledge at all: timeout.
        doFetch(16'h0030, MAX_WAIT + 1, 16'h0000, 1'b0, 1'b0);
        // Acknowledge in the last allowed cycle. This also checks that a
        // fetch still works after a fault.
        doFetch(16'h0040, MAX_WAIT, 16'hC0DE, 1'b0, 1'b0);
        holdEnd(16'hC0DE, 1'b0);
        // Flush in the same cycle as memAck.
        doFetch(16'h0050, 1, 16'hDEAD, 1'b1, 1'b0);
        // Back-to-back fetch out of HOLD.
        doFetch(16'h0060, 0, 16'hBEEF, 1'b0, 1'b0);
        holdStrays(16'hBEEF, 2);
        doFetch(16'h0012, 0, 16'h5A5A, 1'b0, 1'b1);
        holdEnd(16'h5A5A, 1'b0);

        // Fetch at an odd address.
`ifdef FETCH_ALIGN_CHECK_EN
        pcCur      = 16'h0013;
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        checkVal("odd_no_req", 32'(memReq), 32'd0);
        checkVal("odd_misaligned", 32'(misaligned), 32'd1);
        tick();
        checkVal("odd_misaligned_sticky", 32'(misaligned), 32'd1);
`else
        doFetch(16'h0013, 0, 16'h7777, 1'b0, 1'b0);
        checkVal("odd_not_flagged", 32'(misaligned), 32'd0);
        holdEnd(16'h7777, 1'b0);
`endif

        // Random transactions.
        inHold   = 1'b0;
        lastData = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            pc = 16'($urandom);
`ifdef FETCH_ALIGN_CHECK_EN
            pc[0] = 1'b0;
`endif
            data  = 16'($urandom);
            delay = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) delay = MAX_WAIT + 1;
            if ($urandom_range(0, 9) == 0) delay = MAX_WAIT;
            fl = ($urandom_range(0, 5) == 0);
            if (inHold && $urandom_range(0, 1) == 1) begin
                holdStrays(lastData, $urandom_range(0, 2));
                doFetch(pc, delay, data, fl, 1'b1);
            end else begin
                if (inHold) holdEnd(lastData, 1'($urandom_range(0, 1)));
                doFetch(pc, delay, data, fl, 1'b0);
            end
            inHold   = (delay <= MAX_WAIT) && !fl;
            lastData = data;
        end
        if (inHold) holdEnd(lastData, 1'b0);
        tick();

        checkVal("adv_total", 32'(advSeen), 32'(expAdv));
        checkVal("fault_final", 32'(fault), 32'(expFault));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
